ddr_pim_request_engine: RTL and testbench
=========================================

# ddr_pim_request_engine

Upstream stage of the DDR SDRAM wrapper: converts a simple valid/ready request/response protocol into the MPMC native port (PIM0) handshake. It manages write-FIFO fill, address request/acknowledge, read-FIFO draining with the reported pop latency, and InitDone gating. One transaction is outstanding at a time; read data is returned through a small credit-managed response buffer.

## Interface
- BEATS, 4: 64-bit beats per transaction; legal values 1 or 4. PIM Size is 4'd0 for 1 and 4'd1 (cacheline) for 4.
- RESP_DEPTH, 4: response buffer entries; must be ≥ BEATS.
- CLK  in  1  single clock, same as the wrapper's PIM clock
- RST_N  in  1  asynchronous, active-low reset
- req_valid / req_ready  in / out  1  request handshake
- req_rnw  in  1  1 = read, 0 = write
- req_addr  in  32  byte address, aligned to BEATS*8
- wdata_valid / wdata_ready  in / out  1  write beat handshake
- wdata  in  64  write beat; wbe  in  8  byte enables
- rdata_valid / rdata_ready  out / in  1  read beat handshake; rdata  out  64
- pim_addr  out  32; pim_addr_req  out  1; pim_addr_ack  in  1; pim_rnw  out  1; pim_size  out  4; pim_rd_mod_wr  out  1
- pim_wr_data  out  64; pim_wr_be  out  8; pim_wr_push  out  1; pim_wr_empty  in  1; pim_wr_almost_full  in  1; pim_wr_flush  out  1 (tied 0)
- pim_rd_data  in  64; pim_rd_pop  out  1; pim_rd_empty  in  1; pim_rd_flush  out  1 (tied 0); pim_rd_latency  in  2 (0..2)
- pim_init_done  in  1
- busy  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, WR_FILL, ADDR, RD_DRAIN.
- IDLE: req_ready = pim_init_done. On accept, latch addr and rnw and clear the beat counter. Write → WR_FILL; read → ADDR.
- WR_FILL: wdata_ready = !pim_wr_almost_full. Each accepted beat gives pim_wr_push=1 in the same cycle, with wdata/wbe passed through combinationally. Any wbe≠8'hFF sets a sticky partial flag. After beat BEATS-1 → ADDR.
- ADDR: pim_addr_req=1 with addr, rnw, size, and rd_mod_wr = (write && partial) held stable until pim_addr_ack. Cycle with ack: write → IDLE; read → RD_DRAIN.
- RD_DRAIN: pim_rd_pop = !pim_rd_empty && credits>0 && pops_issued<BEATS.
  - Each pop consumes one credit and enters a latency shift register of depth pim_rd_latency (sampled at ADDR ack).
  - Matured entries capture pim_rd_data into the response buffer.
  - rdata is served from the buffer head; each dequeue returns a credit.
  - After BEATS beats are dequeued → IDLE.
- Credits = RESP_DEPTH − (buffered + in flight); never negative.
- Reset values: all handshake/strobe outputs 0, rdata 0, pim_addr/pim_size/pim_rnw 0, pim_rd_mod_wr 0, state IDLE, credits=RESP_DEPTH.

## Timing
- Request accept to pim_addr_req, read: 1 cycle. Write: BEATS accepted beats, then pim_addr_req the next cycle.
- pim_rd_pop to buffer write: pim_rd_latency cycles. Latency 0 captures in the pop cycle. Buffer head drives rdata the cycle after capture.
- Simultaneous enqueue and dequeue on the buffer are both honoured; occupancy is unchanged.
- Simultaneous pop and credit return: credit count is unchanged.
- Full buffer with rdata_ready low: pops stop and no data is lost.
- pim_wr_almost_full mid-burst: push stalls, beat count is held, and the burst resumes when it deasserts.
- RST_N low mid-transaction: return to IDLE asynchronously and clear the buffer and shift register. The MPMC is reset by the same domain.
- pim_init_done low: no request accepted. A transaction already in flight completes.

## Structure
- Shared package ddr_pim_pkg:
  - state enum
  - PIM size codes (SIZE_WORD=4'd0, SIZE_CL4=4'd1)
  - beat/data/BE width constants
- Sub-module ddr_pim_resp_fifo: RESP_DEPTH×64 synchronous FIFO with count output and async active-low reset.

## Test plan
- Reset and init: RST_N low, then high with init_done=0. req_ready stays 0 while req_valid=1. It rises the cycle init_done goes high.
- Full-line write: addr 0x100, 4 beats, wbe=FF. Expect 4 pushes, then addr_req with size=1, rnw=0, rd_mod_wr=0. An ack delayed 5 cycles holds addr_req stable for all 5; IDLE follows the ack.
- Partial write: beat 2 wbe=0x0F. Expect rd_mod_wr=1 at addr_req.
- Read, latency 2: the model returns 0xA0..0xA3. Expect rdata sequence 0xA0,0xA1,0xA2,0xA3 in order, each exactly once.
- Read backpressure, latency 0: rdata_ready low for 10 cycles. Pops stop at RESP_DEPTH with no overflow; all 4 beats are delivered after release.
- Almost-full stall mid-write: almost_full high for 3 cycles after beat 1. wdata_ready and push are 0 for those cycles and exactly 4 pushes occur in total. Also assert RST_N low in ADDR: addr_req drops to 0 asynchronously.

Source files
------------

// File: rtl/ddr_pim_pkg.sv
// Shared types and constants for the PIM request engine and its response buffer.
package ddr_pim_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR_FILL,
    ADDR,
    RD_DRAIN
  } pimState_e;

  localparam logic [3:0] SIZE_WORD = 4'd0;
  localparam logic [3:0] SIZE_CL4  = 4'd1;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned BE_W   = 8;
  localparam int unsigned ADDR_W = 32;

  localparam logic [BE_W-1:0] BE_FULL = '1;

  function automatic logic [3:0] sizeCode(input int unsigned beats);
    return (beats == 4) ? SIZE_CL4 : SIZE_WORD;
  endfunction

endpackage

// File: rtl/ddr_pim_resp_fifo.sv
// Small synchronous FIFO holding read beats; head is visible combinationally.
module ddr_pim_resp_fifo
  import ddr_pim_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wrEn,
  input  logic [WIDTH-1:0]             wrData,
  input  logic                         rdEn,
  output logic [WIDTH-1:0]             rdData,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doWrite;
  logic             doRead;

  assign empty   = (count == '0);
  assign doWrite = wrEn && (count != FULL_CNT);
  assign doRead  = rdEn && !empty;
  assign rdData  = empty ? '0 : mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doWrite) mem[wrPtr] <= wrData;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doWrite) wrPtr <= (wrPtr == LAST_PTR) ? '0 : wrPtr + 1'b1;
      if (doRead)  rdPtr <= (rdPtr == LAST_PTR) ? '0 : rdPtr + 1'b1;
      // Concurrent enqueue and dequeue leave occupancy unchanged.
      unique case ({doWrite, doRead})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ddr_pim_request_engine.sv
// Bridges a valid/ready request/response interface onto the MPMC PIM port, one transaction
// at a time, with credit-limited read popping into a local response buffer.
module ddr_pim_request_engine
  import ddr_pim_pkg::*;
#(
  parameter int unsigned BEATS      = 4,
  parameter int unsigned RESP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rnw,
  input  logic [31:0]       req_addr,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [63:0]       wdata,
  input  logic [7:0]        wbe,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [63:0]       rdata,
  output logic [31:0]       pim_addr,
  output logic              pim_addr_req,
  input  logic              pim_addr_ack,
  output logic              pim_rnw,
  output logic [3:0]        pim_size,
  output logic              pim_rd_mod_wr,
  output logic [63:0]       pim_wr_data,
  output logic [7:0]        pim_wr_be,
  output logic              pim_wr_push,
  input  logic              pim_wr_empty,
  input  logic              pim_wr_almost_full,
  output logic              pim_wr_flush,
  input  logic [63:0]       pim_rd_data,
  output logic              pim_rd_pop,
  input  logic              pim_rd_empty,
  output logic              pim_rd_flush,
  input  logic [1:0]        pim_rd_latency,
  input  logic              pim_init_done,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(BEATS + 1);
  localparam int unsigned OCC_W = $clog2(RESP_DEPTH + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] NUM_BEATS = CNT_W'(BEATS);
  localparam logic [OCC_W:0]   DEPTH_C   = (OCC_W + 1)'(RESP_DEPTH);

  pimState_e        state;
  logic [31:0]      addrQ;
  logic             rnwQ;
  logic             partialQ;
  logic [3:0]       sizeQ;
  logic [CNT_W-1:0] beatCnt;
  logic [CNT_W-1:0] popsIssued;
  logic [CNT_W-1:0] deqCnt;
  logic [1:0]       latQ;
  logic [1:0]       pipeQ;

  logic             reqAccept;
  logic             wrAccept;
  logic             capture;
  logic             deq;
  logic             fifoEmpty;
  logic [OCC_W-1:0] fifoCount;
  logic [OCC_W:0]   used;
  logic [OCC_W:0]   credits;

  assign req_ready   = (state == IDLE) && pim_init_done;
  assign reqAccept   = req_valid && req_ready;
  assign wdata_ready = (state == WR_FILL) && !pim_wr_almost_full;
  assign wrAccept    = wdata_valid && wdata_ready;

  assign pim_wr_push  = wrAccept;
  assign pim_wr_data  = wdata;
  assign pim_wr_be    = wbe;
  assign pim_wr_flush = 1'b0;
  assign pim_rd_flush = 1'b0;

  assign pim_addr_req  = (state == ADDR);
  assign pim_addr      = addrQ;
  assign pim_rnw       = rnwQ;
  assign pim_size      = sizeQ;
  assign pim_rd_mod_wr = !rnwQ && partialQ;
  assign busy          = (state != IDLE);

  // Credits cover both buffered beats and pops still travelling through the latency pipe.
  assign used    = {1'b0, fifoCount} + (OCC_W + 1)'(pipeQ[0]) + (OCC_W + 1)'(pipeQ[1]);
  assign credits = DEPTH_C - used;

  assign pim_rd_pop = (state == RD_DRAIN) && !pim_rd_empty && (credits != '0) &&
                      (popsIssued < NUM_BEATS);

  always_comb begin
    capture = 1'b0;
    unique case (latQ)
      2'd0:    capture = pim_rd_pop;
      2'd1:    capture = pipeQ[0];
      default: capture = pipeQ[1];
    endcase
  end

  assign rdata_valid = !fifoEmpty;
  assign deq         = rdata_valid && rdata_ready;

  ddr_pim_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (DATA_W)
  ) u_respFifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wrEn   (capture),
    .wrData (pim_rd_data),
    .rdEn   (deq),
    .rdData (rdata),
    .empty  (fifoEmpty),
    .count  (fifoCount)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addrQ      <= '0;
      rnwQ       <= 1'b0;
      partialQ   <= 1'b0;
      sizeQ      <= SIZE_WORD;
      beatCnt    <= '0;
      popsIssued <= '0;
      deqCnt     <= '0;
      latQ       <= '0;
      pipeQ      <= '0;
    end else begin
      // Entry 0 matures next cycle (latency 1); entry 1 two cycles out (latency 2+).
      pipeQ <= {pipeQ[0] && latQ[1], pim_rd_pop && (latQ != 2'd0)};
      unique case (state)
        IDLE: begin
          if (reqAccept) begin
            addrQ    <= req_addr;
            rnwQ     <= req_rnw;
            partialQ <= 1'b0;
            sizeQ    <= sizeCode(BEATS);
            beatCnt  <= '0;
            state    <= req_rnw ? ADDR : WR_FILL;
          end
        end
        WR_FILL: begin
          if (wrAccept) begin
            if (wbe != BE_FULL) partialQ <= 1'b1;
            if (beatCnt == LAST_BEAT) state <= ADDR;
            else beatCnt <= beatCnt + 1'b1;
          end
        end
        ADDR: begin
          if (pim_addr_ack) begin
            latQ       <= pim_rd_latency;
            popsIssued <= '0;
            deqCnt     <= '0;
            state      <= rnwQ ? RD_DRAIN : IDLE;
          end
        end
        RD_DRAIN: begin
          if (pim_rd_pop) popsIssued <= popsIssued + 1'b1;
          if (deq) begin
            if (deqCnt == LAST_BEAT) state <= IDLE;
            else deqCnt <= deqCnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_pim_request_engine.sv
// Randomised self-checking bench for ddr_pim_request_engine with a behavioural MPMC model.
module tb_ddr_pim_request_engine;

  localparam int BEATS      = 4;
  localparam int RESP_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 0, req_ready, req_rnw = 0;
  logic [31:0] req_addr = '0;
  logic        wdata_valid = 0, wdata_ready;
  logic [63:0] wdata = '0;
  logic [7:0]  wbe = '0;
  logic        rdata_valid, rdata_ready = 0;
  logic [63:0] rdata;
  logic [31:0] pim_addr;
  logic        pim_addr_req, pim_addr_ack = 0, pim_rnw, pim_rd_mod_wr;
  logic [3:0]  pim_size;
  logic [63:0] pim_wr_data;
  logic [7:0]  pim_wr_be;
  logic        pim_wr_push, pim_wr_empty = 1, pim_wr_almost_full = 0, pim_wr_flush;
  logic [63:0] pim_rd_data;
  logic        pim_rd_pop, pim_rd_empty, pim_rd_flush;
  logic [1:0]  pim_rd_latency = 0;
  logic        pim_init_done = 0;
  logic        busy;

  int tests = 0;
  int fails = 0;

  // MPMC read model: beats are returned pim_rd_latency cycles after each pop.
  logic [63:0] rdMem [256];
  int          rdIdx = 0;
  int          rdCnt = 0;
  logic        gap = 0;
  logic [63:0] dly0 = '0, dly1 = '0;
  int          popCount = 0;

  logic [63:0] gotWrD [$];
  logic [7:0]  gotWrB [$];
  logic [63:0] gotRd  [$];

  logic [63:0] wrData [BEATS];
  logic [7:0]  wrBe   [BEATS];
  logic [63:0] rdVals [BEATS];

  localparam logic [3:0] EXP_SIZE = (BEATS == 4) ? 4'd1 : 4'd0;

  assign pim_rd_empty = (rdIdx >= rdCnt) || gap;
  assign pim_rd_data  = (pim_rd_latency == 2'd0) ? ((rdIdx < rdCnt) ? rdMem[rdIdx] : 64'h0) :
                        (pim_rd_latency == 2'd1) ? dly0 : dly1;

  ddr_pim_request_engine #(
    .BEATS      (BEATS),
    .RESP_DEPTH (RESP_DEPTH)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_rnw            (req_rnw),
    .req_addr           (req_addr),
    .wdata_valid        (wdata_valid),
    .wdata_ready        (wdata_ready),
    .wdata              (wdata),
    .wbe                (wbe),
    .rdata_valid        (rdata_valid),
    .rdata_ready        (rdata_ready),
    .rdata              (rdata),
    .pim_addr           (pim_addr),
    .pim_addr_req       (pim_addr_req),
    .pim_addr_ack       (pim_addr_ack),
    .pim_rnw            (pim_rnw),
    .pim_size           (pim_size),
    .pim_rd_mod_wr      (pim_rd_mod_wr),
    .pim_wr_data        (pim_wr_data),
    .pim_wr_be          (pim_wr_be),
    .pim_wr_push        (pim_wr_push),
    .pim_wr_empty       (pim_wr_empty),
    .pim_wr_almost_full (pim_wr_almost_full),
    .pim_wr_flush       (pim_wr_flush),
    .pim_rd_data        (pim_rd_data),
    .pim_rd_pop         (pim_rd_pop),
    .pim_rd_empty       (pim_rd_empty),
    .pim_rd_flush       (pim_rd_flush),
    .pim_rd_latency     (pim_rd_latency),
    .pim_init_done      (pim_init_done),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pim_rd_pop) begin
      dly0     <= rdMem[rdIdx];
      rdIdx    <= rdIdx + 1;
      popCount <= popCount + 1;
    end else begin
      dly0 <= '0;
    end
    dly1 <= dly0;
    if (pim_wr_push) begin
      gotWrD.push_back(pim_wr_data);
      gotWrB.push_back(pim_wr_be);
    end
    if (rdata_valid && rdata_ready) gotRd.push_back(rdata);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic do_write(input logic [31:0] addr, input int ackDelay, input int stallAfter,
                          input int stallCycles, input bit resetInAddr);
    logic expRmw;
    bit   acc;
    expRmw = 1'b0;
    for (int k = 0; k < BEATS; k++) if (wrBe[k] != 8'hFF) expRmw = 1'b1;
    gotWrD.delete();
    gotWrB.delete();
    @(negedge clk);
    req_valid = 1; req_rnw = 0; req_addr = addr;
    @(negedge clk);
    req_valid = 0;
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL wr_accept: busy=%b required 1", busy);
    end
    for (int k = 0; k < BEATS; k++) begin
      wdata_valid = 1; wdata = wrData[k]; wbe = wrBe[k];
      if (k == stallAfter + 1 && stallCycles > 0) begin
        pim_wr_almost_full = 1;
        for (int s = 0; s < stallCycles; s++) begin
          #1;
          tests++;
          if (wdata_ready !== 1'b0 || pim_wr_push !== 1'b0) begin
            fails++;
            $display("FAIL wr_stall: wdata_ready=%b push=%b required 0/0", wdata_ready,
                     pim_wr_push);
          end
          @(negedge clk);
        end
        pim_wr_almost_full = 0;
      end
      acc = 0;
      for (int t = 0; t < 20 && !acc; t++) begin
        #1;
        acc = wdata_ready;
        @(negedge clk);
      end
      tests++;
      if (!acc) begin
        fails++; $display("FAIL wr_beat_timeout: beat %0d never accepted", k);
      end
    end
    wdata_valid = 0;
    tests++;
    if (gotWrD.size() != BEATS) begin
      fails++; $display("FAIL wr_push_count: got %0d required %0d", gotWrD.size(), BEATS);
    end
    for (int k = 0; k < BEATS && k < gotWrD.size(); k++) begin
      tests++;
      if (gotWrD[k] !== wrData[k] || gotWrB[k] !== wrBe[k]) begin
        fails++;
        $display("FAIL wr_push_data[%0d]: got %h/%h required %h/%h", k, gotWrD[k], gotWrB[k],
                 wrData[k], wrBe[k]);
      end
    end
    tests++;
    if (pim_addr_req !== 1'b1 || pim_addr !== addr || pim_rnw !== 1'b0 ||
        pim_size !== EXP_SIZE || pim_rd_mod_wr !== expRmw) begin
      fails++;
      $display("FAIL wr_addr_req: req=%b addr=%h rnw=%b size=%0d rmw=%b required 1/%h/0/%0d/%b",
               pim_addr_req, pim_addr, pim_rnw, pim_size, pim_rd_mod_wr, addr, EXP_SIZE, expRmw);
    end
    if (resetInAddr) begin
      #2 rst_n = 0;
      #1;
      tests++;
      if (pim_addr_req !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL async_reset: addr_req=%b busy=%b required 0/0", pim_addr_req, busy);
      end
      @(negedge clk);
      rst_n = 1;
      return;
    end
    for (int d = 0; d < ackDelay; d++) begin
      @(negedge clk);
      tests++;
      if (pim_addr_req !== 1'b1 || pim_addr !== addr || pim_rd_mod_wr !== expRmw ||
          pim_size !== EXP_SIZE) begin
        fails++;
        $display("FAIL wr_addr_hold: req=%b addr=%h rmw=%b size=%0d required 1/%h/%b/%0d",
                 pim_addr_req, pim_addr, pim_rd_mod_wr, pim_size, addr, expRmw, EXP_SIZE);
      end
    end
    pim_addr_ack = 1;
    @(negedge clk);
    pim_addr_ack = 0;
    tests++;
    if (busy !== 1'b0 || pim_addr_req !== 1'b0) begin
      fails++; $display("FAIL wr_done: busy=%b addr_req=%b required 0/0", busy, pim_addr_req);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [1:0] lat, input int holdCycles,
                         input bit randReady);
    int popBase;
    int cyc;
    for (int k = 0; k < BEATS; k++) rdMem[rdIdx + k] = rdVals[k];
    rdCnt = rdIdx + BEATS;
    popBase = popCount;
    gotRd.delete();
    pim_rd_latency = lat;
    @(negedge clk);
    req_valid = 1; req_rnw = 1; req_addr = addr;
    @(negedge clk);
    req_valid = 0;
    tests++;
    if (pim_addr_req !== 1'b1 || pim_addr !== addr || pim_rnw !== 1'b1 ||
        pim_size !== EXP_SIZE || pim_rd_mod_wr !== 1'b0) begin
      fails++;
      $display("FAIL rd_addr_req: req=%b addr=%h rnw=%b size=%0d rmw=%b required 1/%h/1/%0d/0",
               pim_addr_req, pim_addr, pim_rnw, pim_size, pim_rd_mod_wr, addr, EXP_SIZE);
    end
    repeat ($urandom_range(0, 3)) @(negedge clk);
    pim_addr_ack = 1;
    @(negedge clk);
    pim_addr_ack = 0;
    cyc = 0;
    while (!(gotRd.size() == BEATS && busy == 1'b0) && cyc < 300) begin
      @(negedge clk);
      if (holdCycles > 0 && cyc == holdCycles) begin
        tests++;
        if (popCount - popBase != RESP_DEPTH || gotRd.size() != 0 || rdata_valid !== 1'b1 ||
            rdata !== rdVals[0]) begin
          fails++;
          $display("FAIL rd_backpressure: pops=%0d delivered=%0d valid=%b rdata=%h required %0d/0/1/%h",
                   popCount - popBase, gotRd.size(), rdata_valid, rdata, RESP_DEPTH, rdVals[0]);
        end
      end
      rdata_ready = (cyc < holdCycles) ? 1'b0 : (randReady ? 1'($urandom_range(0, 1)) : 1'b1);
      gap = randReady ? ($urandom_range(0, 3) == 0) : 1'b0;
      cyc++;
    end
    gap = 0;
    rdata_ready = 0;
    tests++;
    if (cyc >= 300) begin
      fails++; $display("FAIL rd_timeout: delivered %0d of %0d beats", gotRd.size(), BEATS);
    end
    for (int k = 0; k < BEATS && k < gotRd.size(); k++) begin
      tests++;
      if (gotRd[k] !== rdVals[k]) begin
        fails++; $display("FAIL rd_data[%0d]: got %h required %h", k, gotRd[k], rdVals[k]);
      end
    end
    repeat (3) @(negedge clk);
    tests++;
    if (gotRd.size() != BEATS || rdata_valid !== 1'b0 || busy !== 1'b0 ||
        popCount - popBase != BEATS) begin
      fails++;
      $display("FAIL rd_exactly_once: delivered=%0d pops=%0d valid=%b busy=%b required %0d/%0d/0/0",
               gotRd.size(), popCount - popBase, rdata_valid, busy, BEATS, BEATS);
    end
  endtask

  task automatic test_reset;
    req_valid = 1; req_rnw = 0; req_addr = 32'h40;
    repeat (3) @(negedge clk);
    tests++;
    if (req_ready !== 0 || pim_addr_req !== 0 || busy !== 0 || rdata_valid !== 0 ||
        rdata !== 64'h0 || pim_size !== 4'd0 || pim_addr !== 32'h0 || pim_rd_pop !== 0 ||
        pim_wr_push !== 0 || pim_rd_mod_wr !== 0 || pim_rnw !== 0) begin
      fails++;
      $display("FAIL reset_state: ready=%b areq=%b busy=%b rvalid=%b rdata=%h size=%0d required all 0",
               req_ready, pim_addr_req, busy, rdata_valid, rdata, pim_size);
    end
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (req_ready !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL init_gate: req_ready=%b busy=%b required 0/0", req_ready, busy);
      end
    end
    pim_init_done = 1;
    #1;
    tests++;
    if (req_ready !== 1'b1) begin
      fails++; $display("FAIL init_ready: req_ready=%b required 1", req_ready);
    end
    req_valid = 0;
    @(negedge clk);
  endtask

  task automatic test_full_write;
    for (int k = 0; k < BEATS; k++) begin
      wrData[k] = {$urandom, $urandom};
      wrBe[k]   = 8'hFF;
    end
    do_write(32'h100, 5, -2, 0, 0);
  endtask

  task automatic test_partial_write;
    for (int k = 0; k < BEATS; k++) begin
      wrData[k] = {$urandom, $urandom};
      wrBe[k]   = (k == 2) ? 8'h0F : 8'hFF;
    end
    do_write(32'h2E0, 1, -2, 0, 0);
  endtask

  task automatic test_read_lat2;
    for (int k = 0; k < BEATS; k++) rdVals[k] = 64'hA0 + 64'(k);
    do_read(32'h200, 2'd2, 0, 0);
  endtask

  task automatic test_read_backpressure;
    for (int k = 0; k < BEATS; k++) rdVals[k] = {$urandom, $urandom};
    do_read(32'h340, 2'd0, 10, 0);
  endtask

  task automatic test_stall_and_reset;
    for (int k = 0; k < BEATS; k++) begin
      wrData[k] = {$urandom, $urandom};
      wrBe[k]   = 8'hFF;
    end
    do_write(32'h480, 0, 1, 3, 1);
  endtask

  task automatic test_random;
    for (int n = 0; n < 10; n++) begin
      logic [31:0] addr;
      addr = $urandom & 32'hFFFF_FFE0;
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < BEATS; k++) rdVals[k] = {$urandom, $urandom};
        do_read(addr, 2'($urandom_range(0, 2)), 0, 1);
      end else begin
        for (int k = 0; k < BEATS; k++) begin
          wrData[k] = {$urandom, $urandom};
          wrBe[k]   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
        end
        do_write(addr, $urandom_range(0, 3), int'($urandom_range(0, 3)) - 1,
                 $urandom_range(0, 2), 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_partial_write();
    test_read_lat2();
    test_read_backpressure();
    test_stall_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
